hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller. It sequences IF/ID stalls and flushes for the 5-stage RV32I core.
- It decodes the instruction entering ID. It compares that instruction against the load currently in EX and against branch/jump redirects resolved in EX.
- It drives hazard_reg, which selects the ID instruction source, and hazard_ctrl, which kills EX-bound side effects. It also drives the PC hold and saturating stall/flush performance counters.

Parameters:
- FLUSH_CYCLES, 2: number of consecutive cycles ID is flushed after a taken redirect, including the redirect cycle. Legal range is 1..7.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- im_data_in  in  32  fresh instruction from instruction memory.
- im_data_buf  in  32  buffered (previous) instruction.
- ex_mem_r  in  1  instruction now in EX is a load.
- ex_rd_addr  in  5  rd of the instruction now in EX.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- pc_write  out  1  1 = PC advances, 0 = PC holds.
- hazard_reg  out  2  ID instruction select: 00 fresh, 01 NOP (32'h13), 10 buffered.
- hazard_ctrl  out  2  00 normal, 01 load-use bubble, 10 flush bubble. Any nonzero value kills reg/mem writes of the instruction leaving ID.
- state_o  out  2  FSM state, for debug.
- stall_cnt  out  CNT_W  number of load-use stall cycles.
- flush_cnt  out  CNT_W  number of flushed ID cycles.

Behaviour:
- States: NORMAL=0, LU_REPLAY=1, FLUSH=2.
- Registers: 3-bit flush counter fcnt and two CNT_W counters.
- All outputs are combinational from the current state and the current inputs. There is no added latency.
- Source instruction for hazard decode:
  - im_data_buf in LU_REPLAY.
  - im_data_in otherwise.
  - In FLUSH, decoding is ignored.
- Source register use by opcode:
  - uses_rs1: opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2: opcodes 0110011, 0100011, 1100011.
- lu_hit = ex_mem_r && ex_rd_addr!=0 && ((uses_rs1 && rs1==ex_rd_addr) || (uses_rs2 && rs2==ex_rd_addr)).
- Input priority: ex_redirect > lu_hit > normal.
- NORMAL:
  - If ex_redirect: hazard_reg=01, hazard_ctrl=10, pc_write=1, fcnt<=FLUSH_CYCLES-1, flush_cnt++. Next state is FLUSH if FLUSH_CYCLES>1, else NORMAL.
  - Else if lu_hit: hazard_reg=00, hazard_ctrl=01, pc_write=0, stall_cnt++, next state LU_REPLAY.
  - Else: hazard_reg=00, hazard_ctrl=00, pc_write=1.
- LU_REPLAY:
  - If ex_redirect: handled exactly as the NORMAL redirect case.
  - Else if lu_hit is re-evaluated on the buffer and is true: hazard_reg=10, hazard_ctrl=01, pc_write=0, stall_cnt++, stay in LU_REPLAY.
  - Else: hazard_reg=10, hazard_ctrl=00, pc_write=1, next state NORMAL.
- FLUSH:
  - hazard_reg=01, hazard_ctrl=10, pc_write=1, flush_cnt++.
  - If ex_redirect: fcnt reloads to FLUSH_CYCLES-1 and the state stays FLUSH.
  - Else fcnt decrements. When fcnt reaches 1 before the decrement, the next state is NORMAL.
- Counters:
  - Both saturate at all-ones and never wrap.
  - They increment on the clock edge that ends the qualifying cycle.
- Reset:
  - Asserting rst (low) at any time forces, asynchronously, state=NORMAL, fcnt=0, stall_cnt=0, flush_cnt=0.
  - During reset the outputs therefore read pc_write=1, hazard_reg=00, hazard_ctrl=00, state_o=0.
  - An in-progress stall or flush is abandoned.
- x0 never triggers a stall. Stores and branches check rs2; LUI, AUIPC and JAL never stall.

Test Plan:
- Load-use: EX has load with ex_rd_addr=5, im_data_in=add x6,x5,x1 (0x00128333) -> cycle0: pc_write=0, hazard_ctrl=01, hazard_reg=00. Cycle1: hazard_reg=10, hazard_ctrl=00, pc_write=1, state returns to NORMAL. stall_cnt=1.
- No false stall: load to x0, or ex_mem_r=0 with matching rd, or a LUI in ID -> pc_write stays 1, hazard_ctrl=00, stall_cnt stays 0.
- Redirect with FLUSH_CYCLES=2: ex_redirect pulse in NORMAL -> two consecutive cycles with hazard_reg=01 and hazard_ctrl=10, then NORMAL. flush_cnt=2.
- Simultaneous events: ex_redirect=1 and lu_hit=1 in the same cycle -> flush is taken, pc_write=1, stall_cnt unchanged. A redirect during LU_REPLAY also goes to FLUSH.
- Back-to-back redirects: a second ex_redirect in the second FLUSH cycle -> fcnt reloads and flushing lasts 3 cycles total. Separately, preload stall_cnt near 2^CNT_W-1 with CNT_W=4 and hold lu_hit for 20 cycles -> the counter stays at 15 and does not wrap.
- Reset mid-flush: assert rst low asynchronously between clock edges while in FLUSH -> outputs return to the reset values immediately and the counters clear. After release, normal decode resumes on the next edge.

Source files
------------

// File: rtl/hazard_if.sv
// Hazard-control bus between the pipeline front end and the hazard unit.
//   master (pipeline): drives the ID instruction candidates and the EX load/redirect
//                      status; receives pc_write, hazard_reg and hazard_ctrl.
//   slave  (hazard unit): the reverse directions.
interface hazard_if;
    logic [31:0] im_data_in;   // fresh instruction from instruction memory
    logic [31:0] im_data_buf;  // buffered (previous) instruction
    logic        ex_mem_r;     // instruction in EX is a load
    logic [4:0]  ex_rd_addr;   // rd of instruction in EX
    logic        ex_redirect;  // branch taken / jump resolved in EX
    logic        pc_write;     // 1 = PC advances, 0 = PC holds
    logic [1:0]  hazard_reg;   // ID source: 00 fresh, 01 NOP, 10 buffered
    logic [1:0]  hazard_ctrl;  // 00 normal, 01 load-use bubble, 10 flush bubble

    modport master (
        output im_data_in, im_data_buf, ex_mem_r, ex_rd_addr, ex_redirect,
        input  pc_write, hazard_reg, hazard_ctrl
    );

    modport slave (
        input  im_data_in, im_data_buf, ex_mem_r, ex_rd_addr, ex_redirect,
        output pc_write, hazard_reg, hazard_ctrl
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core: detects load-use
// hazards against the load in EX, sequences ID flushes after EX redirects,
// and keeps saturating stall/flush performance counters.
//   clk, rst     : clock, asynchronous active-low reset
//   bus (slave)  : instruction candidates, EX status, pc_write/hazard_reg/hazard_ctrl
//   state_o      : FSM state (debug)
//   stall_cnt    : load-use stall cycles
//   flush_cnt    : flushed ID cycles
module hazard_ctrl_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_if.slave          bus,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int unsigned FCNT_W       = 3;
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic        MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    localparam logic [1:0] SEL_FRESH = 2'b00;
    localparam logic [1:0] SEL_NOP   = 2'b01;
    localparam logic [1:0] SEL_BUF   = 2'b10;
    localparam logic [1:0] CTRL_NORM = 2'b00;
    localparam logic [1:0] CTRL_LU   = 2'b01;
    localparam logic [1:0] CTRL_FL   = 2'b10;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        LU_REPLAY = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [FCNT_W-1:0] fcnt, fcnt_nxt;
    logic              stall_inc, flush_inc;

    logic [31:0] dec_instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic        uses_rs1, uses_rs2, lu_hit;

    // Load-use detection; during a replay the held (buffered) instruction is re-checked.
    always_comb begin
        dec_instr = (state == LU_REPLAY) ? bus.im_data_buf : bus.im_data_in;
        opcode    = dec_instr[6:0];
        rs1       = dec_instr[19:15];
        rs2       = dec_instr[24:20];
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
            default: ;
        endcase
        lu_hit = bus.ex_mem_r && (bus.ex_rd_addr != 5'd0) &&
                 ((uses_rs1 && (rs1 == bus.ex_rd_addr)) ||
                  (uses_rs2 && (rs2 == bus.ex_rd_addr)));
    end

    // Next state and combinational outputs; reset forces the idle output values.
    always_comb begin
        state_nxt       = state;
        fcnt_nxt        = fcnt;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        bus.pc_write    = 1'b1;
        bus.hazard_reg  = SEL_FRESH;
        bus.hazard_ctrl = CTRL_NORM;
        if (rst) begin
            case (state)
                NORMAL, LU_REPLAY: begin
                    if (bus.ex_redirect) begin
                        bus.hazard_reg  = SEL_NOP;
                        bus.hazard_ctrl = CTRL_FL;
                        flush_inc       = 1'b1;
                        fcnt_nxt        = FLUSH_RELOAD;
                        state_nxt       = MULTI_FLUSH ? FLUSH : NORMAL;
                    end else begin
                        bus.hazard_reg = (state == LU_REPLAY) ? SEL_BUF : SEL_FRESH;
                        if (lu_hit) begin
                            bus.hazard_ctrl = CTRL_LU;
                            bus.pc_write    = 1'b0;
                            stall_inc       = 1'b1;
                            state_nxt       = LU_REPLAY;
                        end else begin
                            state_nxt = NORMAL;
                        end
                    end
                end
                FLUSH: begin
                    bus.hazard_reg  = SEL_NOP;
                    bus.hazard_ctrl = CTRL_FL;
                    flush_inc       = 1'b1;
                    if (bus.ex_redirect) begin
                        fcnt_nxt = FLUSH_RELOAD;
                    end else begin
                        fcnt_nxt = fcnt - FCNT_W'(1);
                        if (fcnt <= FCNT_W'(1)) begin
                            state_nxt = NORMAL;
                        end
                    end
                end
                default: state_nxt = NORMAL;
            endcase
        end
    end

    // State, flush counter and saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= NORMAL;
            fcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: two instances (FLUSH_CYCLES=2/CNT_W=32
// and FLUSH_CYCLES=1/CNT_W=4) share one stimulus stream and are compared every
// cycle against a rule-level reference model.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] in_d, buf_d;
    logic        mem_r, redir;
    logic [4:0]  rd;

    hazard_if if0 ();
    hazard_if if1 ();

    assign if0.im_data_in = in_d;  assign if1.im_data_in = in_d;
    assign if0.im_data_buf = buf_d; assign if1.im_data_buf = buf_d;
    assign if0.ex_mem_r = mem_r;   assign if1.ex_mem_r = mem_r;
    assign if0.ex_rd_addr = rd;    assign if1.ex_rd_addr = rd;
    assign if0.ex_redirect = redir; assign if1.ex_redirect = redir;

    logic [1:0]  st0, st1;
    logic [31:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    hazard_ctrl_unit #(.FLUSH_CYCLES(2), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .state_o(st0), .stall_cnt(sc0), .flush_cnt(fc0));
    hazard_ctrl_unit #(.FLUSH_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .state_o(st1), .stall_cnt(sc1), .flush_cnt(fc1));

    // Reference model: remaining flush cycles, replay flag, counters.
    int               fcyc[2] = '{2, 1};
    longint unsigned  cmax[2] = '{64'hFFFF_FFFF, 64'd15};
    int               flush_left[2];
    bit               replay[2];
    longint unsigned  m_stall[2], m_flush[2];

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADD_X6_X5_X1 = 32'h0012_8333;
    localparam logic [31:0] ADD_X6_X0_X1 = 32'h0010_0333;
    localparam logic [31:0] LUI_RS1F_5   = 32'h0002_8337;
    localparam logic [31:0] SW_X5_X1     = 32'h0050_A023;
    localparam logic [31:0] BEQ_X1_X5    = 32'h0050_8063;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    function automatic bit m_hit(logic [31:0] ins);
        bit r1, r2;
        r1 = 1'b0;
        r2 = 1'b0;
        case (ins[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: begin r1 = 1'b1; r2 = 1'b1; end
            7'b0010011, 7'b0000011, 7'b1100111: r1 = 1'b1;
            default: ;
        endcase
        return mem_r && (rd != 0) &&
               ((r1 && ins[19:15] == rd) || (r2 && ins[24:20] == rd));
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            flush_left[d] = 0;
            replay[d]     = 1'b0;
            m_stall[d]    = 0;
            m_flush[d]    = 0;
        end
    endtask

    task automatic check_reset(string tag);
        check({tag, " d0 pc_write"}, 64'(if0.pc_write), 64'd1);
        check({tag, " d0 hazard_reg"}, 64'(if0.hazard_reg), 64'd0);
        check({tag, " d0 hazard_ctrl"}, 64'(if0.hazard_ctrl), 64'd0);
        check({tag, " d0 state"}, 64'(st0), 64'd0);
        check({tag, " d0 stall_cnt"}, 64'(sc0), 64'd0);
        check({tag, " d0 flush_cnt"}, 64'(fc0), 64'd0);
        check({tag, " d1 stall_cnt"}, 64'(sc1), 64'd0);
        check({tag, " d1 flush_cnt"}, 64'(fc1), 64'd0);
    endtask

    // One clock cycle: compare at the falling edge, advance the model, step past the rising edge.
    task automatic cycle(string tag);
        logic [63:0] o_pcw, o_reg, o_ctrl, o_st, o_sc, o_fc;
        logic [63:0] e_pcw, e_reg, e_ctrl, e_st;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                o_pcw = 64'(if0.pc_write); o_reg = 64'(if0.hazard_reg);
                o_ctrl = 64'(if0.hazard_ctrl); o_st = 64'(st0);
                o_sc = 64'(sc0); o_fc = 64'(fc0);
            end else begin
                o_pcw = 64'(if1.pc_write); o_reg = 64'(if1.hazard_reg);
                o_ctrl = 64'(if1.hazard_ctrl); o_st = 64'(st1);
                o_sc = 64'(sc1); o_fc = 64'(fc1);
            end
            e_st = (flush_left[d] > 0) ? 64'd2 : (replay[d] ? 64'd1 : 64'd0);
            check($sformatf("%s d%0d state", tag, d), o_st, e_st);
            check($sformatf("%s d%0d stall_cnt", tag, d), o_sc, m_stall[d]);
            check($sformatf("%s d%0d flush_cnt", tag, d), o_fc, m_flush[d]);
            if (flush_left[d] > 0 || redir) begin
                e_pcw = 1; e_reg = 1; e_ctrl = 2;
                if (m_flush[d] < cmax[d]) m_flush[d]++;
                flush_left[d] = redir ? fcyc[d] - 1 : flush_left[d] - 1;
                replay[d] = 1'b0;
            end else begin
                e_reg = replay[d] ? 64'd2 : 64'd0;
                if (m_hit(replay[d] ? buf_d : in_d)) begin
                    e_pcw = 0; e_ctrl = 1;
                    if (m_stall[d] < cmax[d]) m_stall[d]++;
                    replay[d] = 1'b1;
                end else begin
                    e_pcw = 1; e_ctrl = 0;
                    replay[d] = 1'b0;
                end
            end
            check($sformatf("%s d%0d pc_write", tag, d), o_pcw, e_pcw);
            check($sformatf("%s d%0d hazard_reg", tag, d), o_reg, e_reg);
            check($sformatf("%s d%0d hazard_ctrl", tag, d), o_ctrl, e_ctrl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_d = NOP; buf_d = NOP; mem_r = 1'b0; rd = 5'd0; redir = 1'b0;
    endtask

    logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 8)];
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        #12;
        check_reset("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load-use then replay from buffer.
        in_d = ADD_X6_X5_X1; buf_d = ADD_X6_X5_X1; mem_r = 1'b1; rd = 5'd5;
        cycle("lu0");
        mem_r = 1'b0; in_d = NOP;
        cycle("lu1");
        check("lu stall_cnt", 64'(sc0), 64'd1);
        idle();
        cycle("lu2");

        // No false stalls.
        in_d = ADD_X6_X0_X1; mem_r = 1'b1; rd = 5'd0;
        cycle("nofs_x0");
        in_d = ADD_X6_X5_X1; mem_r = 1'b0; rd = 5'd5;
        cycle("nofs_noload");
        in_d = LUI_RS1F_5; mem_r = 1'b1;
        cycle("nofs_lui");
        check("nofs stall_cnt", 64'(sc0), 64'd1);

        // Store and branch check rs2.
        idle(); in_d = SW_X5_X1; buf_d = NOP; mem_r = 1'b1; rd = 5'd5;
        cycle("sw");
        mem_r = 1'b0;
        cycle("sw_rep");
        in_d = BEQ_X1_X5; mem_r = 1'b1;
        cycle("beq");
        idle();
        cycle("beq_rep");

        // Single redirect.
        redir = 1'b1;
        cycle("rd0");
        redir = 1'b0;
        cycle("rd1");
        cycle("rd2");
        check("redirect flush_cnt", 64'(fc0), 64'd2);

        // Redirect and load-use together; then redirect during replay.
        in_d = ADD_X6_X5_X1; buf_d = ADD_X6_X5_X1; mem_r = 1'b1; rd = 5'd5; redir = 1'b1;
        cycle("sim0");
        redir = 1'b0; mem_r = 1'b0;
        cycle("sim1");
        mem_r = 1'b1;
        cycle("rep0");
        redir = 1'b1;
        cycle("rep_redir");
        idle();
        cycle("rep_f1");
        cycle("rep_f2");

        // Back-to-back redirects: flush stretches to three cycles.
        redir = 1'b1;
        cycle("b2b0");
        cycle("b2b1");
        redir = 1'b0;
        cycle("b2b2");
        cycle("b2b3");

        // Sustained load-use: the 4-bit counter must saturate.
        in_d = ADD_X6_X5_X1; buf_d = ADD_X6_X5_X1; mem_r = 1'b1; rd = 5'd5;
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat d1 stall_cnt", 64'(sc1), 64'd15);
        idle();
        cycle("sat_end");

        // Reset while flushing.
        redir = 1'b1;
        cycle("mid0");
        redir = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        in_d = ADD_X6_X5_X1; buf_d = NOP; mem_r = 1'b1; rd = 5'd5;
        cycle("post0");
        idle();
        cycle("post1");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_d  = rand_instr();
            buf_d = rand_instr();
            mem_r = 1'($urandom_range(0, 1));
            rd    = 5'($urandom_range(0, 3));
            redir = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
